slave_completion_matcher: RTL and testbench

// - Response-side consumer of the slave-bridge request recorder. Takes completion descriptors (P2A path),

---
 rtl/slave_completion_matcher.sv | 121 ++++++++++++
 tb/tb_slave_completion_matcher.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/slave_completion_matcher.sv
// Completion-side matcher for the slave bridge: looks up each completion by tag, updates or retires the record, emits one AXI response.
// Optional UNEXP_CPL_CNT_EN adds a saturating 8-bit counter of completions that hit an invalid entry.
module slave_completion_matcher #(
    parameter int TAG_W = 5,
    parameter int ID_W  = 4,
    parameter int BC_W  = 12,
    parameter int REC_W = 1 + ID_W + 2*BC_W
) (
    input  logic             clk,
    input  logic             ARESET,
    input  logic             cpl_valid,
    output logic             cpl_ready,
    input  logic [TAG_W-1:0] cpl_tag,
    input  logic [BC_W-1:0]  cpl_byte_cnt,
    input  logic [BC_W-1:0]  cpl_len,
    input  logic [2:0]       cpl_status,
    output logic [TAG_W-1:0] rec_rd_addr,
    input  logic [REC_W-1:0] rec_rd_data,
    output logic             rec_wr_en,
    output logic [TAG_W-1:0] rec_wr_addr,
    output logic [REC_W-1:0] rec_wr_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic [1:0]       rsp_resp,
    output logic             rsp_last,
    output logic             tag_free,
    output logic [TAG_W-1:0] tag_free_id,
    output logic             unexp_cpl
`ifdef UNEXP_CPL_CNT_EN
    ,
    output logic [7:0]       unexp_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITE, RESP} state_t;

    state_t             state, state_nxt;
    logic [TAG_W-1:0]   tag_q;
    logic [BC_W-1:0]    bc_q, len_q;
    logic [2:0]         status_q;
    logic [REC_W-2:0]   rec_q;   // record without its valid bit (known set past LOOKUP)

    logic [ID_W-1:0]    rec_id;
    logic [BC_W-1:0]    rec_exp, rec_rcv;
    logic [BC_W:0]      sum;
    logic               err, last, rd_valid;

    assign rec_id   = rec_q[REC_W-2 -: ID_W];
    assign rec_exp  = rec_q[2*BC_W-1 -: BC_W];
    assign rec_rcv  = rec_q[BC_W-1:0];
    assign rd_valid = rec_rd_data[REC_W-1];

    // Record and descriptor registers stay stable from WRITE through RESP,
    // so err/last can stay combinational for the whole response phase.
    assign sum  = {1'b0, rec_rcv} + {1'b0, len_q};
    assign err  = (status_q != 3'b000) || (sum > {1'b0, rec_exp});
    assign last = err || (bc_q == len_q);

    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET) begin
            tag_q    <= '0;
            bc_q     <= '0;
            len_q    <= '0;
            status_q <= '0;
            rec_q    <= '0;
        end else begin
            if (state == IDLE && cpl_valid) begin
                tag_q    <= cpl_tag;
                bc_q     <= cpl_byte_cnt;
                len_q    <= cpl_len;
                status_q <= cpl_status;
            end
            if (state == LOOKUP)
                rec_q <= rec_rd_data[REC_W-2:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpl_valid) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = rd_valid ? WRITE : IDLE;
            WRITE:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // All outputs are gated by state so they read zero outside their phase.
    assign cpl_ready   = (state == IDLE);
    assign rec_rd_addr = (state == LOOKUP) ? tag_q : '0;
    assign unexp_cpl   = (state == LOOKUP) && !rd_valid;

    assign rec_wr_en   = (state == WRITE);
    assign rec_wr_addr = rec_wr_en ? tag_q : '0;
    assign rec_wr_data = rec_wr_en ? {~last, rec_id, rec_exp, sum[BC_W-1:0]} : '0;

    assign rsp_valid   = (state == RESP);
    assign rsp_id      = rsp_valid ? rec_id : '0;
    assign rsp_resp    = (rsp_valid && err) ? 2'b10 : 2'b00;
    assign rsp_last    = rsp_valid && last;

    assign tag_free    = rsp_valid && rsp_ready && last;
    assign tag_free_id = tag_free ? tag_q : '0;

`ifdef UNEXP_CPL_CNT_EN
    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET)
            unexp_cnt <= '0;
        else if (unexp_cpl && unexp_cnt != 8'hFF)
            unexp_cnt <= unexp_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_slave_completion_matcher.sv
// Directed bench for slave_completion_matcher with a behavioural recorder model.
module tb_slave_completion_matcher;

    localparam int TAG_W = 5;
    localparam int ID_W  = 4;
    localparam int BC_W  = 12;
    localparam int REC_W = 1 + ID_W + 2*BC_W;

    logic             clk = 1'b0;
    logic             ARESET = 1'b1;
    logic             cpl_valid = 1'b0;
    logic             cpl_ready;
    logic [TAG_W-1:0] cpl_tag = '0;
    logic [BC_W-1:0]  cpl_byte_cnt = '0;
    logic [BC_W-1:0]  cpl_len = '0;
    logic [2:0]       cpl_status = '0;
    logic [TAG_W-1:0] rec_rd_addr;
    logic [REC_W-1:0] rec_rd_data;
    logic             rec_wr_en;
    logic [TAG_W-1:0] rec_wr_addr;
    logic [REC_W-1:0] rec_wr_data;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [ID_W-1:0]  rsp_id;
    logic [1:0]       rsp_resp;
    logic             rsp_last;
    logic             tag_free;
    logic [TAG_W-1:0] tag_free_id;
    logic             unexp_cpl;
`ifdef UNEXP_CPL_CNT_EN
    logic [7:0]       unexp_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // recorder model; preload port shares the single write process
    logic [REC_W-1:0] mem [2**TAG_W];
    logic             pl_en = 1'b0;
    logic [TAG_W-1:0] pl_addr = '0;
    logic [REC_W-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (rec_wr_en)  mem[rec_wr_addr] <= rec_wr_data;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end
    assign rec_rd_data = mem[rec_rd_addr];

    always #5 clk = ~clk;

    slave_completion_matcher #(.TAG_W(TAG_W), .ID_W(ID_W), .BC_W(BC_W)) dut (
        .clk(clk), .ARESET(ARESET),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag),
        .cpl_byte_cnt(cpl_byte_cnt), .cpl_len(cpl_len), .cpl_status(cpl_status),
        .rec_rd_addr(rec_rd_addr), .rec_rd_data(rec_rd_data),
        .rec_wr_en(rec_wr_en), .rec_wr_addr(rec_wr_addr), .rec_wr_data(rec_wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_resp(rsp_resp), .rsp_last(rsp_last),
        .tag_free(tag_free), .tag_free_id(tag_free_id), .unexp_cpl(unexp_cpl)
`ifdef UNEXP_CPL_CNT_EN
        , .unexp_cnt(unexp_cnt)
`endif
    );

    function automatic logic [REC_W-1:0] rec(input logic v, input logic [ID_W-1:0] id,
                                             input logic [BC_W-1:0] ex, input logic [BC_W-1:0] rc);
        return {v, id, ex, rc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [TAG_W-1:0] a, input logic [REC_W-1:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Returns at the negedge of the LOOKUP cycle.
    task automatic issue(input logic [TAG_W-1:0] t, input logic [BC_W-1:0] bc,
                         input logic [BC_W-1:0] ln, input logic [2:0] st);
        @(negedge clk);
        chk("cpl_ready_idle", cpl_ready, 1);
        cpl_valid = 1'b1; cpl_tag = t; cpl_byte_cnt = bc; cpl_len = ln; cpl_status = st;
        @(negedge clk);
        cpl_valid = 1'b0;
    endtask

    task automatic run(input logic [TAG_W-1:0] t, input logic [BC_W-1:0] bc,
                       input logic [BC_W-1:0] ln, input logic [2:0] st,
                       input logic [REC_W-1:0] ew, input logic [ID_W-1:0] eid,
                       input logic [1:0] eresp, input logic elast);
        issue(t, bc, ln, st);
        chk("lookup_addr", rec_rd_addr, t);
        chk("lookup_unexp", unexp_cpl, 0);
        chk("busy_ready", cpl_ready, 0);
        @(negedge clk);
        chk("wr_en", rec_wr_en, 1);
        chk("wr_addr", rec_wr_addr, t);
        chk("wr_data", rec_wr_data, ew);
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, eid);
        chk("rsp_resp", rsp_resp, eresp);
        chk("rsp_last", rsp_last, elast);
        chk("tag_free", tag_free, elast);
        chk("tag_free_id", tag_free_id, elast ? t : 5'd0);
        chk("wr_en_once", rec_wr_en, 0);
        @(negedge clk);
        chk("rsp_drop", rsp_valid, 0);
        chk("ready_back", cpl_ready, 1);
        chk("mem_entry", mem[t], ew);
    endtask

    initial begin
        for (int i = 0; i < 2**TAG_W; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_cpl_ready", cpl_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_wr_en", rec_wr_en, 0);
        chk("rst_tag_free", tag_free, 0);
        chk("rst_unexp", unexp_cpl, 0);
        ARESET = 1'b0;
        @(negedge clk);
        chk("idle_ready", cpl_ready, 1);

        // single completion
        preload(5, rec(1, 3, 64, 0));
        run(5, 64, 64, 3'b000, rec(0, 3, 64, 64), 3, 2'b00, 1);

        // split completion
        preload(7, rec(1, 9, 128, 0));
        run(7, 128, 64, 3'b000, rec(1, 9, 128, 64), 9, 2'b00, 0);
        run(7, 64, 64, 3'b000, rec(0, 9, 128, 128), 9, 2'b00, 1);

        // UR status
        preload(2, rec(1, 6, 32, 0));
        run(2, 32, 32, 3'b001, rec(0, 6, 32, 32), 6, 2'b10, 1);

        // reserved status treated as CA
        preload(14, rec(1, 1, 8, 0));
        run(14, 8, 8, 3'b011, rec(0, 1, 8, 8), 1, 2'b10, 1);

        // overflow
        preload(12, rec(1, 4, 32, 0));
        run(12, 64, 64, 3'b000, rec(0, 4, 32, 64), 4, 2'b10, 1);

        // zero-length
        preload(13, rec(1, 2, 16, 0));
        run(13, 0, 0, 3'b000, rec(0, 2, 16, 0), 2, 2'b00, 1);

        // unexpected completion
        preload(10, rec(0, 7, 20, 4));
        issue(10, 8, 8, 3'b000);
        chk("unexp_pulse", unexp_cpl, 1);
        @(negedge clk);
        chk("unexp_clear", unexp_cpl, 0);
        chk("unexp_no_wr", rec_wr_en, 0);
        chk("unexp_no_rsp", rsp_valid, 0);
        chk("unexp_idle", cpl_ready, 1);
        chk("unexp_mem", mem[10], rec(0, 7, 20, 4));
`ifdef UNEXP_CPL_CNT_EN
        chk("unexp_cnt", unexp_cnt, 1);
`endif

        // backpressure then reset during RESP
        preload(20, rec(1, 5, 64, 0));
        rsp_ready = 1'b0;
        issue(20, 64, 32, 3'b000);
        @(negedge clk);
        chk("bp_wr_data", rec_wr_data, rec(1, 5, 64, 32));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 5);
            chk("bp_resp", rsp_resp, 2'b00);
            chk("bp_last", rsp_last, 0);
            chk("bp_ready", cpl_ready, 0);
            chk("bp_free", tag_free, 0);
        end
        ARESET = 1'b1;
        #1;
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_rsp_id", rsp_id, 0);
        chk("ar_rsp_resp", rsp_resp, 0);
        chk("ar_rsp_last", rsp_last, 0);
        chk("ar_wr_en", rec_wr_en, 0);
        chk("ar_tag_free", tag_free, 0);
        chk("ar_unexp", unexp_cpl, 0);
        chk("ar_cpl_ready", cpl_ready, 1);
`ifdef UNEXP_CPL_CNT_EN
        chk("ar_unexp_cnt", unexp_cnt, 0);
`endif
        @(negedge clk);
        ARESET = 1'b0;
        rsp_ready = 1'b1;
        chk("ar_mem", mem[20], rec(1, 5, 64, 32));

        // recovery: finish the request that was interrupted
        run(20, 32, 32, 3'b000, rec(0, 5, 64, 64), 5, 2'b00, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
